// File: rtl/lsu_dbus_master.sv
// Load/store initiator on the core data bus: one RV32 load/store becomes one bus
// transaction with lane select, write replication, misalign/timeout detection and load extension.
module lsu_dbus_master #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_stall_o,
  output logic            lsu_valid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_misalign_o,
  output logic            lsu_err_o,
  output logic            dbus_req_o,
  output logic            dbus_w_en_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_sel_byte_o,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_ack_i,
  input  logic            dbus_store_busy_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            valid_q, valid_d, mis_q, mis_d, err_q, err_d;

  logic [1:0]      sz;
  logic            bad;
  logic [3:0]      sel_new;
  logic [XLEN-1:0] wdata_new, ext;
  logic [7:0]      bsel;
  logic [15:0]     hsel;

  assign sz = lsu_funct3_i[1:0];

  // Request decode: misalignment, illegal funct3, lane select and store replication
  always_comb begin
    bad = 1'b0;
    if (sz == 2'b01 && lsu_addr_i[0])           bad = 1'b1;
    if (sz == 2'b10 && lsu_addr_i[1:0] != 2'b00) bad = 1'b1;
    if (sz == 2'b11)                             bad = 1'b1;
    if (lsu_we_i && lsu_funct3_i[2])             bad = 1'b1;
    if (!lsu_we_i && lsu_funct3_i == 3'b110)     bad = 1'b1;
    case (sz)
      2'b00:   sel_new = 4'b0001 << lsu_addr_i[1:0];
      2'b01:   sel_new = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      default: sel_new = 4'b1111;
    endcase
    case (sz)
      2'b00:   wdata_new = {4{lsu_wdata_i[7:0]}};
      2'b01:   wdata_new = {2{lsu_wdata_i[15:0]}};
      default: wdata_new = lsu_wdata_i;
    endcase
  end

  // Load field extraction uses the latched address/funct3
  always_comb begin
    bsel = dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    hsel = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (f3_q)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b100:  ext = {24'b0, bsel};
      3'b101:  ext = {16'b0, hsel};
      default: ext = dbus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (bad) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = lsu_we_i ? STORE : LOAD;
            req_d   = 1'b1;
            we_d    = lsu_we_i;
            addr_d  = lsu_addr_i;
            wdata_d = wdata_new;
            sel_d   = sel_new;
            f3_d    = lsu_funct3_i;
            cnt_d   = '0;
          end
        end
      end
      LOAD, STORE: begin
        // Completion takes priority over a timeout landing in the same cycle
        if ((state_q == LOAD) ? dbus_ack_i : !dbus_store_busy_i) begin
          valid_d = 1'b1;
          if (state_q == LOAD) rdata_d = ext;
          state_d = RESP;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign lsu_stall_o     = (state_q == LOAD) || (state_q == STORE) || (state_q == IDLE && lsu_req_i);
  assign lsu_valid_o     = valid_q;
  assign lsu_misalign_o  = mis_q;
  assign lsu_err_o       = err_q;
  assign lsu_rdata_o     = rdata_q;
  assign dbus_req_o      = req_q;
  assign dbus_w_en_o     = we_q;
  assign dbus_addr_o     = addr_q;
  assign dbus_wdata_o    = wdata_q;
  assign dbus_sel_byte_o = sel_q;
endmodule

// File: doc/lsu_dbus_master.md
# lsu_dbus_master

Load/store initiator on the core's data bus. Sits between the execute stage and the data-bus responders (dual-port data memory, peripherals). Turns one RV32 load/store into a bus transaction: byte-lane select generation, write-data lane replication, misalignment and timeout detection, and load-data sign/zero extension. Stalls the pipeline until each transaction completes.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT, 15, max cycles in LOAD/STORE before a bus error is flagged; must be ≥3.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- lsu_req_i  in  1  execute stage presents a memory op; held high, with operands, until the RESP cycle
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_funct3_i  in  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data (rs2)
- lsu_stall_o  out  1  freeze the pipeline
- lsu_valid_o  out  1  one-cycle completion pulse for a good transaction
- lsu_rdata_o  out  32  extended load data
- lsu_misalign_o  out  1  one-cycle pulse: misaligned access or illegal funct3
- lsu_err_o  out  1  one-cycle pulse: bus timeout
- dbus_req_o  out  1  bus request
- dbus_w_en_o  out  1  bus write enable
- dbus_addr_o  out  32  bus address, full byte address
- dbus_wdata_o  out  32  lane-replicated write data
- dbus_sel_byte_o  out  4  byte-lane select
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  load acknowledge (may be combinational, same cycle as req)
- dbus_store_busy_i  in  1  responder is still processing a store

## Operation
- FSM states: IDLE, LOAD, STORE, RESP. All dbus_* outputs, lsu_rdata_o and the pulse outputs are registered.
- **IDLE**, lsu_req_i = 1:
  - If misaligned or illegal: go to RESP with the misalign flag set. No bus transaction.
  - Misaligned means halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Illegal means funct3 ∉ {000, 001, 010, 100, 101} for loads, or funct3 ∉ {000, 001, 010} for stores.
  - Otherwise go to LOAD or STORE. Load dbus_req_o = 1, w_en, addr, sel_byte and wdata; clear the timeout counter.
- **sel_byte**:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 if addr[1] = 0, else 1100.
  - Word: 1111.
  - Loads drive sel_byte the same way.
- **wdata**:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
- **LOAD**: on dbus_ack_i, extract the field and go to RESP.
  - Byte = rdata >> 8·addr[1:0]. Half = rdata[31:16] if addr[1] = 1, else rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - dbus_store_busy_i is ignored in LOAD.
- **STORE**: the store completes in the first STORE cycle with dbus_store_busy_i = 0; then go to RESP.
  - req, addr, wdata and sel_byte are held stable through that cycle, because the responder writes at the end of it.
  - dbus_ack_i is ignored in STORE.
- **Timeout**: the counter increments each LOAD/STORE cycle without completion. When it reaches TIMEOUT, go to RESP with the error flag set, and lsu_rdata_o = 0.
- **Simultaneous ack/busy-low and timeout in the same cycle**: completion wins; no error.
- **Leaving LOAD/STORE** (any cause): dbus_req_o = 0 and dbus_w_en_o = 0 in the next cycle.
- **RESP**:
  - Exactly one of lsu_valid_o / lsu_misalign_o / lsu_err_o = 1.
  - lsu_stall_o = 0. Go to IDLE unconditionally; lsu_req_i is not sampled in RESP.
- **lsu_stall_o** (combinational) = (state ∈ {LOAD, STORE}) | (state = IDLE & lsu_req_i).
- **lsu_rdata_o**: holds its last value outside RESP; unchanged after stores and misaligned accesses.

## Timing
- Reset: state IDLE; counter 0; all outputs 0. Async reset mid-transaction drops dbus_req_o immediately, with no pulse afterwards. The responder shares rst_n.
- Load, zero-wait responder, 3 cycles:
  - N: IDLE accepts.
  - N+1: LOAD, req = 1, ack.
  - N+2: RESP, valid.
- Load with k wait cycles: RESP at N+2+k.
- Store vs. data memory, 5 cycles:
  - N: accept.
  - N+1, N+2: STORE with busy = 1.
  - N+3: busy = 0; the memory writes.
  - N+4: RESP, req = 0.
- Misaligned access: N accept, N+1 RESP with misalign pulse; dbus_req_o never rises.
- Timeout: with no ack, RESP with err occurs TIMEOUT+1 cycles after N+1.
- Back-to-back ops: next accept at the earliest in the cycle after RESP.

## Test plan
- LB addr 0x103, mem word 0x80FF_1234 → lsu_rdata_o 0xFFFF_FF80 at N+2, sel_byte 1000; LBU same → 0x0000_0080.
- SH addr 0x202, wdata 0x0000_BEEF, old word 0x1111_2222 → sel 1100, wdata 0xBEEF_BEEF; reading back gives 0xBEEF_2222; valid at N+4; req low at N+4.
- LW addr 0x101 → misalign pulse at N+1, dbus_req_o stays 0, lsu_rdata_o unchanged.
- Load with ack held low → lsu_err_o at N+1+TIMEOUT+1 (N+17 with default), rdata 0, req low afterwards.
- Ack asserted in the same cycle the counter hits TIMEOUT → valid = 1, err = 0.
- rst_n pulsed low in the N+2 cycle of an SW → req 0 immediately, no valid pulse, FSM IDLE, memory word unchanged.
